// File: rtl/sweep_scheduler_if.sv
// Sweep scheduler bus: start/abort control, sonar handshake and
// recorded-sample outputs grouped for the servo/sonar sweep block.
interface sweep_scheduler_if;
    logic       do_sweep;
    logic       abort;
    logic       measure_ready;
    logic [7:0] inches;
    logic [8:0] servo_angle;
    logic       do_measure;
    logic       sample_valid;
    logic [8:0] sample_angle;
    logic [7:0] sample_inches;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport master (
        output do_sweep, abort, measure_ready, inches,
        input  servo_angle, do_measure, sample_valid,
        input  sample_angle, sample_inches,
        input  busy, done, timeout_err
    );

    modport slave (
        input  do_sweep, abort, measure_ready, inches,
        output servo_angle, do_measure, sample_valid,
        output sample_angle, sample_inches,
        output busy, done, timeout_err
    );
endinterface

// File: rtl/sweep_scheduler.sv
// Servo sweep scheduler: steps a servo 0..ANGLE_MAX..0, lets it settle,
// requests a sonar reading at each angle and records (angle, distance).
module sweep_scheduler #(
    parameter int ANGLE_MAX     = 270,
    parameter int ANGLE_STEP    = 5,
    parameter int SETTLE_CYCLES = 2000000,
    parameter int MEAS_TIMEOUT  = 4000000
) (
    input logic              clk,
    input logic              rst_n,
    sweep_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, MEASURE, RECORD, STEP, DONE
    } state_t;

    localparam logic [9:0]  AMAX   = 10'(ANGLE_MAX);
    localparam logic [9:0]  ASTEP  = 10'(ANGLE_STEP);
    localparam logic [31:0] SET_LD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] MT_LD  = 32'(MEAS_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [8:0]  angle_q, angle_d;
    logic [31:0] cnt_q, cnt_d;
    logic [8:0]  sa_q, sa_d;
    logic [7:0]  si_q, si_d;
    logic        tmo;

    logic [9:0] ext;
    logic [9:0] up;

    assign ext = {1'b0, angle_q};
    assign up  = ext + ASTEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            angle_q <= '0;
            cnt_q   <= '0;
            sa_q    <= '0;
            si_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            angle_q <= angle_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            si_q    <= si_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        angle_d = angle_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        si_d    = si_q;
        tmo     = 1'b0;
        // abort outranks any handshake or timeout in the same cycle
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            dir_d   = 1'b0;
            angle_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.do_sweep) begin
                        state_d = SETTLE;
                        dir_d   = 1'b0;
                        angle_d = '0;
                        cnt_d   = SET_LD;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = MEASURE;
                        cnt_d   = MT_LD;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                MEASURE: begin
                    if (bus.measure_ready) begin
                        state_d = RECORD;
                        sa_d    = angle_q;
                        si_d    = bus.inches;
                    end else if (cnt_q == '0) begin
                        state_d = RECORD;
                        sa_d    = angle_q;
                        si_d    = 8'hFF;
                        tmo     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                RECORD: begin
                    if (dir_q && angle_q == '0) state_d = DONE;
                    else                        state_d = STEP;
                end
                STEP: begin
                    state_d = SETTLE;
                    cnt_d   = SET_LD;
                    if (!dir_q) begin
                        if (ext == AMAX) begin
                            dir_d   = 1'b1;
                            angle_d = (AMAX >= ASTEP) ?
                                      9'(AMAX - ASTEP) : '0;
                        end else if (up > AMAX) begin
                            angle_d = 9'(AMAX);
                        end else begin
                            angle_d = 9'(up);
                        end
                    end else begin
                        angle_d = (ext < ASTEP) ?
                                  '0 : 9'(ext - ASTEP);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    dir_d   = 1'b0;
                    angle_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.servo_angle   = angle_q;
    assign bus.do_measure    = (state_q == MEASURE) && !bus.abort;
    assign bus.sample_valid  = (state_q == RECORD) && !bus.abort;
    assign bus.sample_angle  = sa_q;
    assign bus.sample_inches = si_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE) && !bus.abort;
    assign bus.timeout_err   = tmo;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: full sweep with one timeout,
// abort, ignored restarts, mid-settle reset and a non-divisible step.
module tb_sweep_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sweep_scheduler_if ia ();
    sweep_scheduler_if ib ();

    sweep_scheduler #(
        .ANGLE_MAX(270), .ANGLE_STEP(5),
        .SETTLE_CYCLES(4), .MEAS_TIMEOUT(16)
    ) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    sweep_scheduler #(
        .ANGLE_MAX(12), .ANGLE_STEP(5),
        .SETTLE_CYCLES(4), .MEAS_TIMEOUT(16)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    function automatic int exp_ang(input int k);
        return (k < 55) ? 5 * k : 270 - 5 * (k - 54);
    endfunction

    function automatic logic [7:0] snr(input int a);
        logic [8:0] v;
        v = 9'(a);
        return v[7:0] ^ 8'h5A;
    endfunction

    bit mon_a = 0, mon_b = 0, tmo_done = 0;
    int ka, kb, n_done_a, n_done_b, n_tmo;
    int tbl_b [7] = '{0, 5, 10, 12, 7, 2, 0};

    // sonar A: answers 3 cycles into MEASURE, stalls once at angle 10
    initial begin : resp_a
        int mc;
        mc = 0;
        ia.measure_ready = 1'b0;
        ia.inches = 8'h00;
        forever begin
            @(negedge clk);
            if (ia.do_measure) mc++;
            else mc = 0;
            ia.measure_ready = 1'b0;
            if (!(ia.servo_angle == 9'd10 && !tmo_done) && mc == 3) begin
                ia.measure_ready = 1'b1;
                ia.inches = snr(int'(ia.servo_angle));
            end
        end
    end

    initial begin : resp_b
        ib.measure_ready = 1'b0;
        ib.inches = 8'h00;
        forever begin
            @(negedge clk);
            ib.measure_ready = ib.do_measure;
            ib.inches = ib.servo_angle[7:0] + 8'd1;
        end
    end

    initial begin : mon
        int mcyc;
        mcyc = 0;
        forever begin
            @(negedge clk);
            if (ia.do_measure) mcyc++;
            else mcyc = 0;
            if (mon_a) begin
                if (ia.sample_valid) begin
                    chk("a_ang", 32'(ia.sample_angle), 32'(exp_ang(ka)));
                    chk("a_inch", 32'(ia.sample_inches),
                        (ka == 2) ? 32'hFF : 32'(snr(exp_ang(ka))));
                    ka++;
                end
                if (ia.timeout_err) begin
                    n_tmo++;
                    chk("tmo_cycles", 32'(mcyc), 32'd16);
                    chk("tmo_ang", 32'(ia.servo_angle), 32'd10);
                    tmo_done = 1;
                end
                if (ia.done) n_done_a++;
            end
            if (mon_b) begin
                if (ib.sample_valid) begin
                    if (kb < 7) begin
                        chk("b_ang", 32'(ib.sample_angle), 32'(tbl_b[kb]));
                        chk("b_inch", 32'(ib.sample_inches),
                            32'(tbl_b[kb] + 1));
                    end else begin
                        chk("b_extra", 32'(kb), 32'd6);
                    end
                    kb++;
                end
                if (ib.done) n_done_b++;
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ang"}, 32'(ia.servo_angle), 0);
        chk({tag, "_meas"}, 32'(ia.do_measure), 0);
        chk({tag, "_sv"}, 32'(ia.sample_valid), 0);
        chk({tag, "_sa"}, 32'(ia.sample_angle), 0);
        chk({tag, "_si"}, 32'(ia.sample_inches), 0);
        chk({tag, "_busy"}, 32'(ia.busy), 0);
        chk({tag, "_done"}, 32'(ia.done), 0);
        chk({tag, "_tmo"}, 32'(ia.timeout_err), 0);
    endtask

    task automatic start_a();
        @(negedge clk);
        ia.do_sweep = 1'b1;
        @(negedge clk);
        ia.do_sweep = 1'b0;
    endtask

    initial begin : main
        bit found;
        int cnt;
        rst_n = 1'b0;
        ia.do_sweep = 1'b0;
        ia.abort = 1'b0;
        ib.do_sweep = 1'b0;
        ib.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        chk("rst_b_busy", 32'(ib.busy), 0);
        rst_n = 1'b1;

        // full sweep with a timeout at 10 and a mid-sweep restart attempt
        ka = 0; n_done_a = 0; n_tmo = 0; tmo_done = 0;
        mon_a = 1;
        start_a();
        chk("start_busy", 32'(ia.busy), 1);
        repeat (200) @(negedge clk);
        ia.do_sweep = 1'b1;
        @(negedge clk);
        ia.do_sweep = 1'b0;
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ia.done) begin
                found = 1;
                break;
            end
        end
        chk("done_seen", 32'(found), 1);
        ia.do_sweep = 1'b1;
        @(negedge clk);
        ia.do_sweep = 1'b0;
        chk("done_ign", 32'(ia.busy), 0);
        repeat (3) @(negedge clk);
        chk("done_ign2", 32'(ia.busy), 0);
        mon_a = 0;
        chk("a_samples", 32'(ka), 32'd109);
        chk("a_dones", 32'(n_done_a), 1);
        chk("a_tmos", 32'(n_tmo), 1);

        // abort in MEASURE at angle 100
        start_a();
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ia.do_measure && ia.servo_angle == 9'd100) begin
                found = 1;
                break;
            end
        end
        chk("abort_reach", 32'(found), 1);
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        chk("abort_busy", 32'(ia.busy), 0);
        chk("abort_ang", 32'(ia.servo_angle), 0);
        chk("abort_meas", 32'(ia.do_measure), 0);
        chk("abort_done", 32'(ia.done), 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ia.done || ia.busy) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 0);

        // reset for one cycle in SETTLE at angle 5
        start_a();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ia.servo_angle == 9'd5) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach", 32'(found), 1);
        chk("rst_pre_sa", 32'(ia.sample_inches), 32'h5A);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outs("mid_rst");
        @(negedge clk);
        chk("mid_rst_idle", 32'(ia.busy), 0);

        // non-divisible step on the small instance
        kb = 0; n_done_b = 0;
        mon_b = 1;
        @(negedge clk);
        ib.do_sweep = 1'b1;
        @(negedge clk);
        ib.do_sweep = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ib.done) begin
                found = 1;
                break;
            end
        end
        @(negedge clk);
        mon_b = 0;
        chk("b_done_seen", 32'(found), 1);
        chk("b_samples", 32'(kb), 32'd7);
        chk("b_dones", 32'(n_done_b), 1);
        chk("b_idle_ang", 32'(ib.servo_angle), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
